// File: rtl/clkgate_ctrl.sv
// Purpose: per-channel clock-enable controller for BUFGCE CE pins (sync, dwell, cascade).
// Latency: sw edge captured at posedge k reaches ce at posedge k+SYNC_STAGES once the dwell has expired.
// Backpressure: none; requests arriving during a dwell are held off, and short pulses may be lost.
module clkgate_ctrl #(
  parameter int unsigned     N_CH        = 2,
  parameter int unsigned     SYNC_STAGES = 2,
  parameter int unsigned     MIN_HOLD    = 4,
  parameter logic [N_CH-1:0] CASCADE     = 2'b10
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic [N_CH-1:0] sw,
  input  logic            force_off,
  output logic [N_CH-1:0] ce,
  output logic [N_CH-1:0] on_st,
  output logic [N_CH-1:0] chg
);

  // Dwell counter is wide enough to hold MIN_HOLD-1 even when MIN_HOLD is a power of two.
  localparam int unsigned HW = $clog2(MIN_HOLD) + 1;
  localparam logic [HW-1:0] HOLD_LOAD = HW'(MIN_HOLD - 1);

  typedef enum logic {
    ST_OFF = 1'b0,
    ST_ON  = 1'b1
  } st_e;

  // sync_q[0] is the only flop that looks at sw; req comes off the last stage.
  logic [N_CH-1:0] sync_q [SYNC_STAGES];
  logic [N_CH-1:0] req;

  st_e             state_q [N_CH];
  st_e             state_d [N_CH];
  logic [HW-1:0]   hcnt_q  [N_CH];
  logic [HW-1:0]   hcnt_d  [N_CH];

  logic [N_CH-1:0] ce_q;
  logic [N_CH-1:0] ce_d;
  logic [N_CH-1:0] chg_q;
  logic [N_CH-1:0] chg_d;

  assign req = sync_q[SYNC_STAGES-1];

  // Synchroniser chains for the asynchronous switch inputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int s = 0; s < int'(SYNC_STAGES); s++) begin
        sync_q[s] <= '0;
      end
    end else begin
      sync_q[0] <= sw;
      for (int s = 1; s < int'(SYNC_STAGES); s++) begin
        sync_q[s] <= sync_q[s-1];
      end
    end
  end

  // Per-channel OFF/ON decision with minimum dwell; force_off bypasses the dwell.
  always_comb begin
    for (int i = 0; i < int'(N_CH); i++) begin
      state_d[i] = state_q[i];
      hcnt_d[i]  = (hcnt_q[i] != '0) ? (hcnt_q[i] - HW'(1)) : '0;
      if (state_q[i] == ST_OFF) begin
        if (req[i] && (hcnt_q[i] == '0) && !force_off) begin
          state_d[i] = ST_ON;
          hcnt_d[i]  = HOLD_LOAD;
        end
      end else begin
        if (force_off || (!req[i] && (hcnt_q[i] == '0))) begin
          state_d[i] = ST_OFF;
          hcnt_d[i]  = HOLD_LOAD;
        end
      end
    end
  end

  // Cascade resolved from next-state values in ascending order, so a parent and its
  // children all land in ce on the same edge instead of rippling one edge per stage.
  always_comb begin
    logic parent;
    parent = 1'b1;
    for (int i = 0; i < int'(N_CH); i++) begin
      if ((i > 0) && CASCADE[i]) begin
        ce_d[i] = (state_d[i] == ST_ON) & parent;
      end else begin
        ce_d[i] = (state_d[i] == ST_ON);
      end
      parent = ce_d[i];
    end
    chg_d = ce_d ^ ce_q;
  end

  // Channel state and dwell counters.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < int'(N_CH); i++) begin
        state_q[i] <= ST_OFF;
        hcnt_q[i]  <= '0;
      end
    end else begin
      for (int i = 0; i < int'(N_CH); i++) begin
        state_q[i] <= state_d[i];
        hcnt_q[i]  <= hcnt_d[i];
      end
    end
  end

  // CE and change pulse are flop outputs only, so no glitch can reach the BUFGCE pins.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ce_q  <= '0;
      chg_q <= '0;
    end else begin
      ce_q  <= ce_d;
      chg_q <= chg_d;
    end
  end

  // on_st reports the raw channel state, before cascade gating.
  always_comb begin
    for (int i = 0; i < int'(N_CH); i++) begin
      on_st[i] = (state_q[i] == ST_ON);
    end
  end

  assign ce  = ce_q;
  assign chg = chg_q;

endmodule

// File: tb/tb_clkgate_ctrl.sv
// Purpose: directed and random checks of clkgate_ctrl against a timestamp-based reference model.
// Latency: outputs sampled 1 time unit after each rising edge.
// Backpressure: not applicable.
module tb_clkgate_ctrl;

  localparam int N = 2;
  localparam int S = 2;
  localparam int M = 4;
  localparam logic [N-1:0] CASC = 2'b10;

  logic         clk = 1'b0;
  logic         rst_n = 1'b1;
  logic [N-1:0] sw = '0;
  logic         force_off = 1'b0;
  logic [N-1:0] ce;
  logic [N-1:0] on_st;
  logic [N-1:0] chg;

  int checks = 0;
  int failures = 0;

  // Reference model: a channel may change on an edge only if at least M edges have
  // passed since its previous change (force_off excepted); req is sw seen S edges ago.
  bit [N-1:0] m_on;
  bit [N-1:0] m_ce;
  bit [N-1:0] m_chg;
  int         m_last [N];
  int         n_edge = 0;
  bit [N-1:0] hist [$];

  clkgate_ctrl #(
    .N_CH       (N),
    .SYNC_STAGES(S),
    .MIN_HOLD   (M),
    .CASCADE    (CASC)
  ) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .sw       (sw),
    .force_off(force_off),
    .ce       (ce),
    .on_st    (on_st),
    .chg      (chg)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_on  = '0;
    m_ce  = '0;
    m_chg = '0;
    for (int i = 0; i < N; i++) m_last[i] = -1000;
    hist.delete();
    for (int s = 0; s < S; s++) hist.push_back('0);
  endtask

  task automatic model_edge();
    bit [N-1:0] req;
    bit [N-1:0] nce;
    bit         allowed;
    bit         parent;
    req = hist.pop_front();
    hist.push_back(sw);
    for (int i = 0; i < N; i++) begin
      allowed = ((n_edge - m_last[i]) >= M);
      if (m_on[i]) begin
        if (force_off || (!req[i] && allowed)) begin
          m_on[i] = 1'b0;
          m_last[i] = n_edge;
        end
      end else if (req[i] && allowed && !force_off) begin
        m_on[i] = 1'b1;
        m_last[i] = n_edge;
      end
    end
    parent = 1'b1;
    for (int i = 0; i < N; i++) begin
      nce[i] = m_on[i] & (((i > 0) && CASC[i]) ? parent : 1'b1);
      parent = nce[i];
    end
    m_chg = nce ^ m_ce;
    m_ce  = nce;
    n_edge++;
  endtask

  // One clock edge: advance the model, then compare every output shortly after the edge.
  task automatic step();
    @(posedge clk);
    model_edge();
    #1;
    chk("ce", 32'(ce), 32'(m_ce));
    chk("on_st", 32'(on_st), 32'(m_on));
    chk("chg", 32'(chg), 32'(m_chg));
  endtask

  // Reset pulse between edges: outputs must clear before any clock edge arrives.
  task automatic mid_reset();
    step();
    #2;
    rst_n = 1'b0;
    #1;
    chk("rst_async_ce", 32'(ce), 32'd0);
    chk("rst_async_on", 32'(on_st), 32'd0);
    chk("rst_async_chg", 32'(chg), 32'd0);
    model_reset();
    @(posedge clk);
    #1;
    chk("rst_hold_ce", 32'(ce), 32'd0);
    #2;
    rst_n = 1'b1;
  endtask

  initial begin
    int         cnt;
    int         k;
    logic [N-1:0] chg_seen;

    model_reset();
    #2;
    rst_n = 1'b0;
    @(posedge clk);
    #1;
    chk("reset_ce", 32'(ce), 32'd0);
    chk("reset_on", 32'(on_st), 32'd0);
    chk("reset_chg", 32'(chg), 32'd0);
    #2;
    rst_n = 1'b1;

    // Idle after reset: nothing turns on, no change pulses.
    chg_seen = '0;
    repeat (20) begin
      step();
      chg_seen |= chg;
    end
    chk("t1_ce", 32'(ce), 32'd0);
    chk("t1_chg_seen", 32'(chg_seen), 32'd0);

    // Single channel: ce[0] rises S edges after the capture edge.
    sw = 2'b01;
    step();
    chk("t2_capture", 32'(ce), 32'd0);
    step();
    chk("t2_edge1", 32'(ce), 32'd0);
    step();
    chk("t2_rise", 32'(ce), 32'b01);
    chk("t2_chg", 32'(chg), 32'b01);
    step();
    chk("t2_chg_end", 32'(chg), 32'd0);

    // Child requested first stays gated, then joins the parent on one edge.
    sw = 2'b00;
    repeat (10) step();
    chk("t3_idle", 32'(ce), 32'd0);
    sw = 2'b10;
    repeat (3) step();
    chk("t3_child_on", 32'(on_st), 32'b10);
    chk("t3_child_gated", 32'(ce), 32'd0);
    sw = 2'b11;
    step();
    step();
    chk("t3_pre", 32'(ce), 32'd0);
    step();
    chk("t3_joint", 32'(ce), 32'b11);
    chk("t3_chg", 32'(chg), 32'b11);
    step();
    chk("t3_chg_once", 32'(chg), 32'd0);

    // One-cycle request still yields exactly M cycles of ce[0].
    sw = 2'b00;
    repeat (12) step();
    chk("t4_idle", 32'(ce), 32'd0);
    sw = 2'b01;
    step();
    sw = 2'b00;
    cnt = 0;
    repeat (12) begin
      step();
      if (ce[0]) cnt++;
    end
    chk("t4_pulse_len", 32'(cnt), 32'(M));
    chk("t4_pulse_off", 32'(ce), 32'd0);

    // Brief drop of the request during the dwell is ignored.
    sw = 2'b11;
    k = 0;
    while ((ce !== 2'b11) && (k < 10)) begin
      step();
      k++;
    end
    chk("t4_rise_lat", 32'(k), 32'(S + 1));
    sw = 2'b00;
    step();
    sw = 2'b11;
    cnt = 0;
    repeat (10) begin
      step();
      if (ce !== 2'b11) cnt++;
    end
    chk("t4_toggle_hold", 32'(cnt), 32'd0);

    // Global kill beats an active request, then the dwell governs the return.
    repeat (3) step();
    force_off = 1'b1;
    step();
    force_off = 1'b0;
    chk("t5_kill", 32'(ce), 32'd0);
    chk("t5_kill_chg", 32'(chg), 32'b11);
    repeat (M - 1) step();
    chk("t5_dwell", 32'(ce), 32'd0);
    step();
    chk("t5_back", 32'(ce), 32'b11);

    // Reset while both channels are on.
    repeat (5) step();
    chk("t6_on", 32'(ce), 32'b11);
    mid_reset();
    step();
    step();
    chk("t6_pre", 32'(ce), 32'd0);
    step();
    chk("t6_back", 32'(ce), 32'b11);
    chk("t6_chg", 32'(chg), 32'b11);

    // Random traffic against the model.
    repeat (400) begin
      if ($urandom_range(3) == 0) sw = N'($urandom_range(3));
      force_off = ($urandom_range(15) == 0);
      if ($urandom_range(99) == 0) mid_reset();
      step();
    end
    force_off = 1'b0;

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
